dmi_uart_host: RTL
==================

// Module: dmi_uart_host
// PURPOSE
//  Host-side endpoint of the DMI-over-UART link; counterpart of the UART TAP.
//  Encodes client requests into command bytes {cmd,addr} plus write-data bytes on
//  the UART TX byte interface. Deserializes TAP read-data bytes from UART RX into
//  response words. Used by the FPGA host bridge and as the TAP's bench driver.
// PARAMETERS
//  WIDTH           $bits(dmi_req_t)  max data word width (bits)
//  TIMEOUT_CYCLES  1024              idle cycles before partial RX frame drop (macro only)
// PORTS
//  CLK_I           in   1          clock
//  RST_NI          in   1          reset; asynchronous, active-low
//  REQ_VALID_I     in   1          client request valid
//  REQ_READY_O     out  1          request accepted when VALID&READY
//  REQ_CMD_I       in   CMDLENGTH  CMD_READ/CMD_CONT_READ/CMD_WRITE/CMD_RESET
//  REQ_ADDR_I      in   IRLENGTH   target address
//  REQ_DATA_I      in   WIDTH      write data (CMD_WRITE only)
//  RSP_VALID_O     out  1          response word valid
//  RSP_READY_I     in   1          response consumed when VALID&READY
//  RSP_ADDR_O      out  IRLENGTH   address the response belongs to
//  RSP_DATA_O      out  WIDTH      response data, zero-extended
//  WRITE_O         out  1          TX byte valid; transfer on WRITE_O&TX_READY_I
//  TX_READY_I      in   1          UART TX can accept a byte
//  DATA_SEND_O     out  8          TX byte
//  SEND_COMMAND_O  out  1          TX byte is a command byte
//  READ_O          out  1          pop RX byte this cycle
//  RX_EMPTY_I      in   1          RX FIFO empty
//  DATA_REC_I      in   8          RX byte
//  CMD_REC_I       in   1          RX byte is a command (address notification)
//  RX_TIMEOUT_O    out  1          one-cycle pulse: partial frame dropped
// BEHAVIOUR
//  Reset: WRITE_O=0, DATA_SEND_O=0, SEND_COMMAND_O=0, RSP_VALID_O=0, RSP_DATA_O=0,
//   RSP_ADDR_O=ADDR_IDCODE, RX_TIMEOUT_O=0, REQ_READY_O=0 while RST_NI low, TX FSM=IDLE,
//   last_cmd=CMD_NOP, rx_addr=ADDR_IDCODE, rx_len=READ_LENGTHS[ADDR_IDCODE].
//  TX FSM IDLE->CMD->DATA->IDLE; REQ_READY_O=(state==IDLE), registered request capture.
//  IDLE: on accept, latch cmd/addr/data, nbytes=(WRITE_LENGTHS[addr]+7)/8.
//   Streaming: CMD_WRITE with last_cmd==CMD_WRITE and same addr skips CMD, goes to DATA.
//   All other cases go to CMD.
//  CMD: DATA_SEND_O={cmd,addr}, SEND_COMMAND_O=1, WRITE_O=1, held until TX_READY_I.
//   On transfer: WRITE->DATA, else ->IDLE.
//  DATA: bytes LSB first, data[8i+:8], SEND_COMMAND_O=0, held until TX_READY_I; IDLE after last.
//  last_cmd updates on CMD byte transfer. nbytes==0 on WRITE: CMD only.
//  Outputs stable while WRITE_O&!TX_READY_I. Min request spacing: 1 idle cycle.
//  RX: READ_O = !RX_EMPTY_I && !RSP_VALID_O (stall while response unconsumed).
//  Popped command byte: rx_addr=byte[IRLENGTH-1:0]; rx_len=READ_LENGTHS[rx_addr];
//   abort partial word; count=0. No response is produced.
//  Popped data byte: rx_reg[count+:8]=byte; count+=8. When count>=rx_len: RSP_VALID_O=1
//   next cycle with rx_reg, rx_addr; count=0, rx_reg cleared for the next frame.
//   rx_len==0: data bytes dropped.
//  CMD_RESET accept also clears the RX frame (count=0), same cycle.
//  RSP_VALID_O & RSP_READY_I same cycle as a new completion: impossible (READ_O stalled).
//  TX and RX paths are independent; simultaneous TX transfer and RX pop allowed.
// CONFIGURATION
//  DMI_UART_HOST_TIMEOUT_EN defined: count>0 and no RX pop for TIMEOUT_CYCLES cycles
//   -> count=0, rx_reg=0, RX_TIMEOUT_O pulses 1 cycle; rx_addr kept.
//  Undefined: no counter; RX_TIMEOUT_O tied 0; partial frames wait indefinitely.
// STRUCTURE
//  uart_pkg: IRLENGTH, CMDLENGTH, CMD_*, ADDR_*, READ_LENGTHS, WRITE_LENGTHS, dmi_req_t;
//   add host_tx_state_e {IDLE,CMD,DATA}.
//  Sub-module dmi_uart_host_deser: RX deserializer plus optional timeout.
//  TX FSM stays in top.
// TESTING
//  WRITE ADDR_DTMCS 0x12345678, TX_READY_I=1 -> cmd-flagged {CMD_WRITE,ADDR_DTMCS}, then 78,56,34,12.
//  Second WRITE same addr 0xCAFEF00D -> no cmd byte, 0D,F0,FE,CA; then READ -> cmd byte sent.
//  TX_READY_I low 5 cycles mid-DATA -> WRITE_O/DATA_SEND_O held stable, no byte lost/duplicated.
//  RX cmd byte {000,ADDR_IDCODE}, data 01,00,00,20 -> RSP_DATA_O=0x20000001, RSP_ADDR_O=ADDR_IDCODE.
//  RSP_READY_I low, 4 more bytes queued -> READ_O=0 until consumed; second word correct.
//  RX 2 data bytes then cmd byte -> partial dropped, no RSP; with _EN, 2 bytes + 1024 idle -> RX_TIMEOUT_O pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared DMI-over-UART definitions: command/address encodings, per-address
// register lengths and the host TX state type.
package uart_pkg;

  localparam int IRLENGTH  = 5;
  localparam int CMDLENGTH = 3;

  localparam logic [CMDLENGTH-1:0] CMD_NOP       = 3'd0;
  localparam logic [CMDLENGTH-1:0] CMD_READ      = 3'd1;
  localparam logic [CMDLENGTH-1:0] CMD_CONT_READ = 3'd2;
  localparam logic [CMDLENGTH-1:0] CMD_WRITE     = 3'd3;
  localparam logic [CMDLENGTH-1:0] CMD_RESET     = 3'd4;

  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_DTMCS  = 5'h10;
  localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  // Register lengths in bits; unlisted addresses carry no data.
  localparam logic [6:0] READ_LENGTHS  [2**IRLENGTH] = '{1: 7'd32, 16: 7'd32, 17: 7'd41, default: 7'd0};
  localparam logic [6:0] WRITE_LENGTHS [2**IRLENGTH] = '{16: 7'd32, 17: 7'd41, default: 7'd0};

  typedef enum logic [1:0] {IDLE, CMD, DATA} host_tx_state_e;

  function automatic logic [2:0] write_nbytes(input logic [IRLENGTH-1:0] addr);
    logic [6:0] w_len;
    w_len = WRITE_LENGTHS[addr] + 7'd7;
    return w_len[5:3];
  endfunction

endpackage

// File: rtl/dmi_uart_host_deser.sv
// RX byte deserializer: assembles read-data bytes into response words.
// Optional partial-frame drop enabled by DMI_UART_HOST_TIMEOUT_EN.
module dmi_uart_host_deser
  import uart_pkg::*;
#(
  parameter int WIDTH          = $bits(dmi_req_t),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx_empty,
  input  logic [7:0]          i_rx_byte,
  input  logic                i_rx_cmd,
  input  logic                i_clear,
  input  logic                i_rsp_ready,
  output logic                o_read,
  output logic                o_rsp_valid,
  output logic [IRLENGTH-1:0] o_rsp_addr,
  output logic [WIDTH-1:0]    o_rsp_data,
  output logic                o_timeout
);
  localparam int RW = ((WIDTH + 7) / 8) * 8;

  logic [RW-1:0]       r_rx_reg, w_merged, w_mask;
  logic [6:0]          r_count, r_rx_len;
  logic [IRLENGTH-1:0] r_rx_addr;
  logic                r_rsp_valid, r_timeout, w_pop, w_timeout_hit;

  assign w_pop       = !i_rx_empty && !r_rsp_valid;
  assign o_read      = w_pop;
  assign o_rsp_valid = r_rsp_valid;
  assign o_timeout   = r_timeout;
  assign w_merged    = r_rx_reg | (RW'(i_rx_byte) << r_count);
  assign w_mask      = (RW'(1) << r_rx_len) - RW'(1);

`ifdef DMI_UART_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle_cnt;

  // Reloads on any pop or while no frame is in progress, so it only runs down on a stalled partial frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                r_idle_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (w_pop || r_count == 7'd0)           r_idle_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (r_idle_cnt != '0)                   r_idle_cnt <= r_idle_cnt - TW'(1);
  end
  assign w_timeout_hit = (r_count != 7'd0) && (r_idle_cnt == '0);
`else
  // TIMEOUT_CYCLES only takes effect when the timeout is compiled in.
  assign w_timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_reg    <= '0;
      r_count     <= '0;
      r_rx_addr   <= ADDR_IDCODE;
      r_rx_len    <= READ_LENGTHS[ADDR_IDCODE];
      r_rsp_valid <= 1'b0;
      o_rsp_addr  <= ADDR_IDCODE;
      o_rsp_data  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_rsp_valid && i_rsp_ready) r_rsp_valid <= 1'b0;
      if (w_pop && i_rx_cmd) begin
        r_rx_addr <= i_rx_byte[IRLENGTH-1:0];
        r_rx_len  <= READ_LENGTHS[i_rx_byte[IRLENGTH-1:0]];
        r_count   <= '0;
        r_rx_reg  <= '0;
      end else if (i_clear) begin
        r_count  <= '0;
        r_rx_reg <= '0;
      end else if (w_pop && r_rx_len != 7'd0) begin
        if (r_count + 7'd8 >= r_rx_len) begin
          r_rsp_valid <= 1'b1;
          o_rsp_addr  <= r_rx_addr;
          o_rsp_data  <= WIDTH'(w_merged & w_mask);
          r_count     <= '0;
          r_rx_reg    <= '0;
        end else begin
          r_rx_reg <= w_merged;
          r_count  <= r_count + 7'd8;
        end
      end else if (w_timeout_hit) begin
        r_count   <= '0;
        r_rx_reg  <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmi_uart_host.sv
// Host endpoint of the DMI-over-UART link: TX request encoder plus RX deserializer.
// Define DMI_UART_HOST_TIMEOUT_EN to drop stalled partial RX frames.
//
// state | meaning
// IDLE  | ready for a client request
// CMD   | presenting {cmd,addr} command byte
// DATA  | presenting write-data bytes, LSB first
module dmi_uart_host
  import uart_pkg::*;
#(
  parameter int WIDTH          = $bits(dmi_req_t),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 REQ_VALID_I,
  output logic                 REQ_READY_O,
  input  logic [CMDLENGTH-1:0] REQ_CMD_I,
  input  logic [IRLENGTH-1:0]  REQ_ADDR_I,
  input  logic [WIDTH-1:0]     REQ_DATA_I,
  output logic                 RSP_VALID_O,
  input  logic                 RSP_READY_I,
  output logic [IRLENGTH-1:0]  RSP_ADDR_O,
  output logic [WIDTH-1:0]     RSP_DATA_O,
  output logic                 WRITE_O,
  input  logic                 TX_READY_I,
  output logic [7:0]           DATA_SEND_O,
  output logic                 SEND_COMMAND_O,
  output logic                 READ_O,
  input  logic                 RX_EMPTY_I,
  input  logic [7:0]           DATA_REC_I,
  input  logic                 CMD_REC_I,
  output logic                 RX_TIMEOUT_O
);
  host_tx_state_e       r_state, w_state_nxt;
  logic [CMDLENGTH-1:0] r_cmd, r_last_cmd;
  logic [IRLENGTH-1:0]  r_addr, r_last_addr;
  logic [WIDTH-1:0]     r_data;
  logic [2:0]           r_nbytes, w_nbytes;
  logic                 w_accept, w_stream, w_xfer;

  assign REQ_READY_O = (r_state == IDLE) && RST_NI;
  assign w_accept    = REQ_VALID_I && REQ_READY_O;
  assign w_nbytes    = write_nbytes(REQ_ADDR_I);
  assign w_xfer      = WRITE_O && TX_READY_I;
  // Back-to-back writes to one register reuse the previous command byte.
  assign w_stream    = (REQ_CMD_I == CMD_WRITE) && (r_last_cmd == CMD_WRITE) &&
                       (REQ_ADDR_I == r_last_addr) && (w_nbytes != 3'd0);

  always_comb begin
    w_state_nxt    = r_state;
    WRITE_O        = 1'b0;
    SEND_COMMAND_O = 1'b0;
    DATA_SEND_O    = '0;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_stream ? DATA : CMD;
      CMD: begin
        WRITE_O        = 1'b1;
        SEND_COMMAND_O = 1'b1;
        DATA_SEND_O    = {r_cmd, r_addr};
        if (TX_READY_I) w_state_nxt = (r_cmd == CMD_WRITE && r_nbytes != 3'd0) ? DATA : IDLE;
      end
      DATA: begin
        WRITE_O     = 1'b1;
        DATA_SEND_O = r_data[7:0];
        if (TX_READY_I && r_nbytes == 3'd1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state     <= IDLE;
      r_cmd       <= CMD_NOP;
      r_addr      <= ADDR_IDCODE;
      r_data      <= '0;
      r_nbytes    <= '0;
      r_last_cmd  <= CMD_NOP;
      r_last_addr <= ADDR_IDCODE;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd    <= REQ_CMD_I;
        r_addr   <= REQ_ADDR_I;
        r_data   <= REQ_DATA_I;
        r_nbytes <= w_nbytes;
      end
      if (w_xfer && r_state == CMD) begin
        r_last_cmd  <= r_cmd;
        r_last_addr <= r_addr;
      end
      if (w_xfer && r_state == DATA) begin
        r_data   <= r_data >> 8;
        r_nbytes <= r_nbytes - 3'd1;
      end
    end
  end

  dmi_uart_host_deser #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_deser (
    .i_clk       (CLK_I),
    .i_rst_n     (RST_NI),
    .i_rx_empty  (RX_EMPTY_I),
    .i_rx_byte   (DATA_REC_I),
    .i_rx_cmd    (CMD_REC_I),
    .i_clear     (w_accept && REQ_CMD_I == CMD_RESET),
    .i_rsp_ready (RSP_READY_I),
    .o_read      (READ_O),
    .o_rsp_valid (RSP_VALID_O),
    .o_rsp_addr  (RSP_ADDR_O),
    .o_rsp_data  (RSP_DATA_O),
    .o_timeout   (RX_TIMEOUT_O)
  );

endmodule
